multi_platform_display: RTL and testbench



---
 rtl/multi_platform_display_pkg.sv | 19 +
 rtl/multi_platform_display_if.sv | 18 +
 rtl/multi_platform_display_hit.sv | 29 ++
 rtl/platform_rom.sv | 12 +
 rtl/multi_platform_display.sv | 93 +++++++++
 tb/tb_multi_platform_display.sv | 143 ++++++++++++++
 6 files changed

// File: rtl/multi_platform_display_pkg.sv
// multi_platform_display_pkg: shared sprite geometry, colour widths and platform ROM contents
package multi_platform_display_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int RGB_W = 12;
  localparam int ROM_ROW_W = 6;
  localparam int ROM_COL_W = 9;
  localparam int CALC_W = 12;
  localparam logic [RGB_W-1:0] DEF_TRANSP = 12'hF0F;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Tile artwork: row in the top nibble, column in the low byte; the origin is the transparent key.
  function automatic logic [RGB_W-1:0] rom_pixel(input logic [ROM_ROW_W-1:0] row, input logic [ROM_COL_W-1:0] col);
    return (row == '0 && col == '0) ? DEF_TRANSP : {4'(row), 8'(col)};
  endfunction
endpackage

// File: rtl/multi_platform_display_if.sv
// multi_platform_display_if: platform positions, pixel coordinates and pixel result
interface multi_platform_display_if import multi_platform_display_pkg::*;
  #(parameter int N_PLAT = 4, parameter int LEN_W = 4, parameter int IDX_W = idx_w(N_PLAT)) ();
  logic frame_tick;
  logic [N_PLAT*X_W-1:0] plat_x;
  logic [N_PLAT*Y_W-1:0] plat_y;
  logic [N_PLAT*LEN_W-1:0] plat_len;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic video_on;
  logic [RGB_W-1:0] rgb_out;
  logic platform_on;
  logic [IDX_W-1:0] hit_idx;
  modport master (output frame_tick, plat_x, plat_y, plat_len, x, y, video_on,
                  input rgb_out, platform_on, hit_idx);
  modport slave (input frame_tick, plat_x, plat_y, plat_len, x, y, video_on,
                 output rgb_out, platform_on, hit_idx);
endinterface

// File: rtl/multi_platform_display_hit.sv
// plat_hit_unit: box test and tile offset for one platform
module plat_hit_unit import multi_platform_display_pkg::*;
  #(parameter int TILE_W = 32, parameter int TILE_H = 16, parameter int LEN_W = 4) (
  input logic [X_W-1:0] sx,
  input logic [Y_W-1:0] sy,
  input logic [LEN_W-1:0] slen,
  input logic [X_W-1:0] x,
  input logic [Y_W-1:0] y,
  input logic video_on,
  output logic hit,
  output logic [ROM_ROW_W-1:0] row,
  output logic [ROM_COL_W-1:0] col
);
  logic [CALC_W-1:0] px, py, bx, by, dx, dy, x_end, y_end;
  // 12-bit compares so platforms near the right/bottom edge end past the screen instead of wrapping
  always_comb begin
    px = CALC_W'(x);
    py = CALC_W'(y);
    bx = CALC_W'(sx);
    by = CALC_W'(sy);
    dx = px - bx;
    dy = py - by;
    x_end = bx + CALC_W'(slen) * CALC_W'(TILE_W);
    y_end = by + CALC_W'(TILE_H);
    hit = video_on && slen != '0 && px >= bx && px < x_end && py >= by && py < y_end;
    col = ROM_COL_W'(dx) & ROM_COL_W'(TILE_W - 1);
    row = ROM_ROW_W'(dy) & ROM_ROW_W'(TILE_H - 1);
  end
endmodule

// File: rtl/platform_rom.sv
// platform_rom: tile artwork with registered read data
module platform_rom import multi_platform_display_pkg::*; (
  input logic clk,
  input logic reset_n,
  input logic [ROM_ROW_W-1:0] row,
  input logic [ROM_COL_W-1:0] col,
  output logic [RGB_W-1:0] data
);
  // synchronous read, cleared by reset so the pipeline starts dark
  always_ff @(posedge clk)
    data <= !reset_n ? '0 : rom_pixel(row, col);
endmodule

// File: rtl/multi_platform_display.sv
// multi_platform_display: double-buffered multi-platform tile renderer, 3-cycle pipeline
module multi_platform_display import multi_platform_display_pkg::*;
  #(parameter int N_PLAT = 4, parameter int TILE_W = 32, parameter int TILE_H = 16,
    parameter int LEN_W = 4, parameter logic [RGB_W-1:0] TRANSP = DEF_TRANSP) (
  input logic clk,
  input logic reset_n,
  multi_platform_display_if.slave bus
);
  localparam int IDX_W = idx_w(N_PLAT);
  logic [X_W-1:0] sx [N_PLAT];
  logic [Y_W-1:0] sy [N_PLAT];
  logic [LEN_W-1:0] slen [N_PLAT];
  logic [N_PLAT-1:0] hit;
  logic [ROM_ROW_W-1:0] row [N_PLAT];
  logic [ROM_COL_W-1:0] col [N_PLAT];
  logic any_hit;
  logic [IDX_W-1:0] win;
  logic [ROM_ROW_W-1:0] win_row;
  logic [ROM_COL_W-1:0] win_col;
  logic s1_hit, s2_hit, draw;
  logic [IDX_W-1:0] s1_idx, s2_idx;
  logic [ROM_ROW_W-1:0] s1_row;
  logic [ROM_COL_W-1:0] s1_col;
  logic [RGB_W-1:0] rom_data;
  // shadow positions change only on frame_tick so a frame never tears
  always_ff @(posedge clk)
    for (int i = 0; i < N_PLAT; i++) begin
      if (!reset_n) begin
        sx[i] <= '0;
        sy[i] <= '0;
        slen[i] <= '0;
      end else if (bus.frame_tick) begin
        sx[i] <= bus.plat_x[i*X_W +: X_W];
        sy[i] <= bus.plat_y[i*Y_W +: Y_W];
        slen[i] <= bus.plat_len[i*LEN_W +: LEN_W];
      end
    end
  for (genvar i = 0; i < N_PLAT; i++) begin : g_unit
    plat_hit_unit #(.TILE_W(TILE_W), .TILE_H(TILE_H), .LEN_W(LEN_W)) u_hit (
      .sx(sx[i]), .sy(sy[i]), .slen(slen[i]), .x(bus.x), .y(bus.y), .video_on(bus.video_on),
      .hit(hit[i]), .row(row[i]), .col(col[i]));
  end
  // priority encoder: scanning downward leaves the lowest-index hit as winner
  always_comb begin
    any_hit = 1'b0;
    win = '0;
    win_row = '0;
    win_col = '0;
    for (int i = N_PLAT - 1; i >= 0; i--)
      if (hit[i]) begin
        any_hit = 1'b1;
        win = IDX_W'(i);
        win_row = row[i];
        win_col = col[i];
      end
  end
  // S1: register hit, winner and ROM address
  always_ff @(posedge clk)
    if (!reset_n) begin
      s1_hit <= 1'b0;
      s1_idx <= '0;
      s1_row <= '0;
      s1_col <= '0;
    end else begin
      s1_hit <= any_hit;
      s1_idx <= win;
      s1_row <= win_row;
      s1_col <= win_col;
    end
  platform_rom u_rom (.clk(clk), .reset_n(reset_n), .row(s1_row), .col(s1_col), .data(rom_data));
  // S2: carry hit and winner alongside the ROM read
  always_ff @(posedge clk)
    if (!reset_n) begin
      s2_hit <= 1'b0;
      s2_idx <= '0;
    end else begin
      s2_hit <= s1_hit;
      s2_idx <= s1_idx;
    end
  // a transparent winner blanks the pixel; lower-priority platforms never show through
  assign draw = s2_hit && rom_data != TRANSP;
  // S3: output register
  always_ff @(posedge clk)
    if (!reset_n) begin
      bus.rgb_out <= '0;
      bus.platform_on <= 1'b0;
      bus.hit_idx <= '0;
    end else begin
      bus.rgb_out <= draw ? rom_data : '0;
      bus.platform_on <= draw;
      bus.hit_idx <= draw ? s2_idx : '0;
    end
endmodule

// File: tb/tb_multi_platform_display.sv
// tb_multi_platform_display: directed checks of the multi-platform renderer
module tb_multi_platform_display;
  localparam int N = 4;
  localparam int LW = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  multi_platform_display_if #(.N_PLAT(N), .LEN_W(LW)) bus ();
  multi_platform_display #(.N_PLAT(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic expect_px(string tag, logic on, logic [11:0] rgb, logic [1:0] idx);
    check({tag, ".on"}, 32'(bus.platform_on), 32'(on));
    check({tag, ".rgb"}, 32'(bus.rgb_out), 32'(rgb));
    check({tag, ".idx"}, 32'(bus.hit_idx), 32'(idx));
  endtask
  task automatic set_plat(int i, int px, int py, int len);
    bus.plat_x[11*i +: 11] = 11'(px);
    bus.plat_y[10*i +: 10] = 10'(py);
    bus.plat_len[LW*i +: LW] = LW'(len);
  endtask
  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask
  task automatic probe(int px, int py, logic v);
    bus.x = 11'(px);
    bus.y = 10'(py);
    bus.video_on = v;
    repeat (3) step();
  endtask
  initial begin
    logic on_e;
    logic [11:0] rgb_e;
    int xp;
    bus.frame_tick = 1'b0;
    bus.plat_x = '0;
    bus.plat_y = '0;
    bus.plat_len = '0;
    bus.x = '0;
    bus.y = '0;
    bus.video_on = 1'b0;
    // reset with every input active
    set_plat(0, 100, 200, 2);
    bus.frame_tick = 1'b1;
    bus.x = 11'd100;
    bus.y = 10'd205;
    bus.video_on = 1'b1;
    reset_n = 1'b0;
    repeat (2) step();
    expect_px("reset", 1'b0, 12'h000, 2'd0);
    reset_n = 1'b1;
    bus.frame_tick = 1'b0;
    repeat (4) begin
      step();
      expect_px("no_tick", 1'b0, 12'h000, 2'd0);
    end
    // scan across platform 0 at (100,200), two tiles
    tick();
    bus.y = 10'd205;
    for (int j = 0; j < 68; j++) begin
      bus.video_on = j <= 65;
      bus.x = 11'(99 + j);
      step();
      if (j >= 2) begin
        xp = 99 + j - 2;
        on_e = xp >= 100 && xp < 164;
        rgb_e = on_e ? {4'h5, 8'((xp - 100) % 32)} : 12'h000;
        expect_px($sformatf("scan_x%0d", xp), on_e, rgb_e, 2'd0);
      end
    end
    // overlap priority, then disable the winner
    set_plat(0, 300, 300, 1);
    set_plat(2, 300, 300, 1);
    tick();
    probe(310, 305, 1'b1);
    expect_px("overlap", 1'b1, 12'h50A, 2'd0);
    set_plat(0, 300, 300, 0);
    tick();
    probe(310, 305, 1'b1);
    expect_px("disable0", 1'b1, 12'h50A, 2'd2);
    // move without frame_tick is invisible until the next tick
    set_plat(2, 400, 300, 1);
    probe(310, 305, 1'b1);
    expect_px("hold", 1'b1, 12'h50A, 2'd2);
    tick();
    probe(310, 305, 1'b1);
    expect_px("moved_old", 1'b0, 12'h000, 2'd0);
    probe(410, 305, 1'b1);
    expect_px("moved_new", 1'b1, 12'h50A, 2'd2);
    // transparent origin with no fall-through to platform 1
    set_plat(0, 400, 300, 1);
    set_plat(1, 399, 300, 1);
    set_plat(2, 0, 0, 0);
    tick();
    probe(400, 300, 1'b1);
    expect_px("transp", 1'b0, 12'h000, 2'd0);
    probe(401, 300, 1'b1);
    expect_px("opaque", 1'b1, 12'h001, 2'd0);
    // right-edge clipping and 12-bit no-wrap
    set_plat(0, 0, 0, 0);
    set_plat(1, 2040, 100, 15);
    set_plat(3, 620, 100, 4);
    tick();
    probe(621, 100, 1'b1);
    expect_px("edge621", 1'b1, 12'h001, 2'd3);
    probe(639, 100, 1'b1);
    expect_px("edge639", 1'b1, 12'h013, 2'd3);
    probe(630, 105, 1'b1);
    expect_px("edge630", 1'b1, 12'h50A, 2'd3);
    probe(619, 105, 1'b1);
    expect_px("left_of", 1'b0, 12'h000, 2'd0);
    probe(0, 105, 1'b1);
    expect_px("nowrap0", 1'b0, 12'h000, 2'd0);
    probe(5, 105, 1'b1);
    expect_px("nowrap5", 1'b0, 12'h000, 2'd0);
    probe(630, 105, 1'b0);
    expect_px("video_off", 1'b0, 12'h000, 2'd0);
    // mid-frame reset blanks until the next tick
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    probe(630, 105, 1'b1);
    expect_px("mid_reset", 1'b0, 12'h000, 2'd0);
    tick();
    probe(630, 105, 1'b1);
    expect_px("after_reset", 1'b1, 12'h50A, 2'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
